branch_flag_unit: RTL and testbench

//  Consumes the registered equal/greater/less flags of the 16-bit comparator and holds them in a flag register.

---
 rtl/branch_flag_unit.sv | 180 ++++++++++++++++++
 tb/tb_branch_flag_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_flag_unit.sv
// Branch flag unit: holds the comparator's one-hot flags and resolves conditional
// branch requests against them, driving a registered PC-load strobe and target.
module branch_flag_unit #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15,
  parameter bit STICKY  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flags_valid,
  input  logic              equal,
  input  logic              greater,
  input  logic              less,
  input  logic              br_req,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              br_ready,
  output logic              br_done,
  output logic              br_taken,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic [2:0]        flags_q,
  output logic              flags_ok,
  output logic              flag_err,
  output logic              br_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FLAGS,
    RESOLVE
  } state_e;

  typedef enum logic [2:0] {
    COND_EQ     = 3'b000,
    COND_NE     = 3'b001,
    COND_GT     = 3'b010,
    COND_LT     = 3'b011,
    COND_GE     = 3'b100,
    COND_LE     = 3'b101,
    COND_ALWAYS = 3'b110,
    COND_NEVER  = 3'b111
  } cond_e;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // f is {equal, greater, less}
  function automatic logic eval_cond(input logic [2:0] cond, input logic [2:0] f);
    logic taken;
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ:     taken = f[2];
      COND_NE:     taken = !f[2];
      COND_GT:     taken = f[1];
      COND_LT:     taken = f[0];
      COND_GE:     taken = f[1] | f[2];
      COND_LE:     taken = f[0] | f[2];
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

  // ALWAYS/NEVER do not depend on the flags and never consume them
  function automatic logic is_uncond(input logic [2:0] cond);
    return cond[2:1] == 2'b11;
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          cond_q, cond_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [2:0]          flags_in;
  logic                flags_legal;
  logic                accept;
  logic                resolve_d;
  logic                taken_d;
  logic                timeout_d;

  assign flags_in    = {equal, greater, less};
  assign flags_legal = flags_valid && $onehot(flags_in);
  assign accept      = br_req && br_ready;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cond_d    = cond_q;
    target_d  = target_q;
    resolve_d = 1'b0;
    taken_d   = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cond_d   = br_cond;
          target_d = br_target;
          if (flags_legal) begin
            resolve_d = 1'b1;
            taken_d   = eval_cond(br_cond, flags_in);
          end else if (is_uncond(br_cond) || flags_ok) begin
            resolve_d = 1'b1;
            taken_d   = eval_cond(br_cond, flags_q);
          end else begin
            state_d = WAIT_FLAGS;
            cnt_d   = '0;
          end
        end
      end
      WAIT_FLAGS: begin
        if (flags_legal) begin
          resolve_d = 1'b1;
          taken_d   = eval_cond(cond_q, flags_in);
        end else if (TIMEOUT != 0 && int'(cnt_q) == TIMEOUT - 1) begin
          resolve_d = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (resolve_d) state_d = RESOLVE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cond_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cond_q   <= cond_d;
      target_q <= target_d;
    end
  end

  // Resolution outputs are registered on the edge that enters RESOLVE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_ready   <= 1'b1;
      br_done    <= 1'b0;
      br_taken   <= 1'b0;
      pc_load    <= 1'b0;
      pc_target  <= '0;
      br_timeout <= 1'b0;
    end else begin
      br_ready   <= (state_d == IDLE);
      br_done    <= resolve_d;
      br_taken   <= taken_d;
      pc_load    <= resolve_d && taken_d;
      br_timeout <= timeout_d;
      if (resolve_d) pc_target <= target_d;
    end
  end

  // A legal capture wins over the consume-on-resolve clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q  <= '0;
      flags_ok <= 1'b0;
      flag_err <= 1'b0;
    end else begin
      flag_err <= flags_valid && !$onehot(flags_in);
      if (flags_legal) begin
        flags_q  <= flags_in;
        flags_ok <= 1'b1;
      end else if (state_q == RESOLVE && !STICKY && !is_uncond(cond_q)) begin
        flags_ok <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed scoreboard bench for branch_flag_unit: a consuming instance for the
// main scenarios and a sticky instance for the condition sweep.
module tb_branch_flag_unit;

  localparam int ADDR_W = 16;

  typedef struct packed {
    logic              taken;
    logic              timeout;
    logic [ADDR_W-1:0] target;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flags_valid = 1'b0;
  logic              equal = 1'b0, greater = 1'b0, less = 1'b0;
  logic              br_req = 1'b0;
  logic [2:0]        br_cond = '0;
  logic [ADDR_W-1:0] br_target = '0;
  logic              sel = 1'b0;

  logic              d_ready, d_done, d_taken, d_load, d_ok, d_err, d_tmo;
  logic [ADDR_W-1:0] d_target;
  logic [2:0]        d_flags;
  logic              s_ready, s_done, s_taken, s_load, s_ok, s_err, s_tmo;
  logic [ADDR_W-1:0] s_target;
  logic [2:0]        s_flags;

  logic              o_ready, o_done, o_taken, o_load, o_ok, o_err, o_tmo;
  logic [ADDR_W-1:0] o_target;
  logic [2:0]        o_flags;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  branch_flag_unit #(.ADDR_W(ADDR_W), .TIMEOUT(15), .STICKY(1'b0)) dut (
    .clk(clk), .rst(rst), .flags_valid(flags_valid),
    .equal(equal), .greater(greater), .less(less),
    .br_req(br_req), .br_cond(br_cond), .br_target(br_target),
    .br_ready(d_ready), .br_done(d_done), .br_taken(d_taken), .pc_load(d_load),
    .pc_target(d_target), .flags_q(d_flags), .flags_ok(d_ok), .flag_err(d_err),
    .br_timeout(d_tmo)
  );

  branch_flag_unit #(.ADDR_W(ADDR_W), .TIMEOUT(15), .STICKY(1'b1)) dut_s (
    .clk(clk), .rst(rst), .flags_valid(flags_valid),
    .equal(equal), .greater(greater), .less(less),
    .br_req(br_req), .br_cond(br_cond), .br_target(br_target),
    .br_ready(s_ready), .br_done(s_done), .br_taken(s_taken), .pc_load(s_load),
    .pc_target(s_target), .flags_q(s_flags), .flags_ok(s_ok), .flag_err(s_err),
    .br_timeout(s_tmo)
  );

  always_comb begin
    o_ready  = sel ? s_ready  : d_ready;
    o_done   = sel ? s_done   : d_done;
    o_taken  = sel ? s_taken  : d_taken;
    o_load   = sel ? s_load   : d_load;
    o_target = sel ? s_target : d_target;
    o_flags  = sel ? s_flags  : d_flags;
    o_ok     = sel ? s_ok     : d_ok;
    o_err    = sel ? s_err    : d_err;
    o_tmo    = sel ? s_tmo    : d_tmo;
  end

  // Branch truth table for a one-hot flag vector f = {e, g, l}
  function automatic logic model_taken(input logic [2:0] c, input logic [2:0] f);
    case (c)
      3'b000:  return f == 3'b100;
      3'b001:  return f != 3'b100;
      3'b010:  return f == 3'b010;
      3'b011:  return f == 3'b001;
      3'b100:  return f != 3'b001;
      3'b101:  return f != 3'b010;
      3'b110:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_flags(input logic [2:0] f);
    flags_valid = 1'b1;
    {equal, greater, less} = f;
    tick();
    flags_valid = 1'b0;
  endtask

  task automatic request(input logic [2:0] c, input logic [ADDR_W-1:0] t);
    br_req    = 1'b1;
    br_cond   = c;
    br_target = t;
    tick();
    br_req = 1'b0;
  endtask

  task automatic push(input logic taken, input logic timeout, input logic [ADDR_W-1:0] t);
    exp_t e;
    e.taken   = taken;
    e.timeout = timeout;
    e.target  = t;
    sb.push_back(e);
  endtask

  // lat counts extra cycles after the acceptance edge before br_done is seen
  task automatic wait_done(input string tag, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    while (o_done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, ".done"}, 32'(o_done), 1);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".taken"}, 32'(o_taken), 32'(e.taken));
      check({tag, ".pc_load"}, 32'(o_load), 32'(e.taken));
      check({tag, ".timeout"}, 32'(o_tmo), 32'(e.timeout));
      if (e.taken) check({tag, ".pc_target"}, 32'(o_target), 32'(e.target));
    end
    tick();
    check({tag, ".done_pulse"}, 32'(o_done), 0);
    check({tag, ".ready_after"}, 32'(o_ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ready"}, 32'(o_ready), 1);
    check({tag, ".others"},
          32'({o_done, o_taken, o_load, o_target, o_flags, o_ok, o_err, o_tmo}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] vecs [3];
    int         seen;
    vecs = '{3'b100, 3'b010, 3'b001};

    // Test 1: reset state, then asynchronous reset in the middle of WAIT_FLAGS
    tick(); tick();
    check_reset_outputs("t1.por");
    rst = 1'b1;
    tick();
    request(3'b011, 16'h00AA);
    tick(); tick();
    check("t1.waiting_ready", 32'(o_ready), 0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("t1.mid_wait");
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_done) seen++;
    end
    check("t1.no_done_after_release", seen, 0);

    // Test 2: held EQ flag, taken branch, flags consumed
    drive_flags(3'b100);
    check("t2.flags_ok", 32'(o_ok), 1);
    check("t2.flags_q", 32'(o_flags), 32'(3'b100));
    push(1'b1, 1'b0, 16'h0040);
    request(3'b000, 16'h0040);
    wait_done("t2", 0);
    check("t2.consumed", 32'(o_ok), 0);

    // Capture during RESOLVE overrides the consume-clear
    drive_flags(3'b100);
    push(1'b1, 1'b0, 16'h0050);
    request(3'b000, 16'h0050);
    flags_valid = 1'b1;
    {equal, greater, less} = 3'b010;
    wait_done("t2b", 0);
    flags_valid = 1'b0;
    check("t2b.flags_ok", 32'(o_ok), 1);
    check("t2b.flags_q", 32'(o_flags), 32'(3'b010));
    push(1'b1, 1'b0, 16'h0060);
    request(3'b010, 16'h0060);
    wait_done("t2c", 0);
    check("t2c.consumed", 32'(o_ok), 0);

    // Test 3: wait for flags; requests while not ready are ignored
    push(1'b1, 1'b0, 16'h1234);
    request(3'b010, 16'h1234);
    check("t3.no_early_done", 32'(o_done), 0);
    br_req    = 1'b1;
    br_cond   = 3'b111;
    br_target = 16'hDEAD;
    tick(); tick();
    check("t3.ready_in_wait", 32'(o_ready), 0);
    br_req = 1'b0;
    drive_flags(3'b010);
    wait_done("t3", 0);
    check("t3.consumed", 32'(o_ok), 0);

    // Test 4: timeout forces not-taken after 15 cycles in WAIT_FLAGS
    push(1'b0, 1'b1, 16'hBEEF);
    request(3'b011, 16'hBEEF);
    wait_done("t4", 15);
    check("t4.flags_ok", 32'(o_ok), 0);

    // Test 5: illegal flag vectors, then unconditional branches
    drive_flags(3'b110);
    check("t5.err_pulse", 32'(o_err), 1);
    check("t5.flags_ok", 32'(o_ok), 0);
    tick();
    check("t5.err_clear", 32'(o_err), 0);
    drive_flags(3'b000);
    check("t5.err_zero_vec", 32'(o_err), 1);
    push(1'b1, 1'b0, 16'h0100);
    request(3'b110, 16'h0100);
    wait_done("t5.always", 0);
    push(1'b0, 1'b0, 16'h0200);
    request(3'b111, 16'h0200);
    wait_done("t5.never", 0);
    check("t5.flags_ok_after", 32'(o_ok), 0);

    // Flags arriving in the acceptance cycle are used directly
    flags_valid = 1'b1;
    {equal, greater, less} = 3'b001;
    push(1'b1, 1'b0, 16'h0300);
    request(3'b001, 16'h0300);
    flags_valid = 1'b0;
    wait_done("t5.same_cycle", 0);
    check("t5.same_cycle_consumed", 32'(o_ok), 0);

    // Test 6: condition sweep on the sticky instance
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    sel = 1'b1;
    tick();
    for (int vi = 0; vi < 3; vi++) begin
      drive_flags(vecs[vi]);
      check($sformatf("t6.v%0d.flags_q", vi), 32'(o_flags), 32'(vecs[vi]));
      for (int c = 0; c < 8; c++) begin
        logic [ADDR_W-1:0] t;
        t = 16'h1000 | 16'(vi * 16 + c);
        push(model_taken(3'(c), vecs[vi]), 1'b0, t);
        request(3'(c), t);
        wait_done($sformatf("t6.v%0d.c%0d", vi, c), 0);
        check($sformatf("t6.v%0d.c%0d.sticky", vi, c), 32'(o_ok), 1);
      end
    end

    check("sb.drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
